// File: rtl/pccmd_sched.sv
// -----------------------------------------------------------------------------
// pccmd_sched
//   Dependency-aware command scheduler in front of the processing-core command
//   controller. Each instruction is held until the outstanding-operation
//   counters it waits on have drained and its own increment fits. It is then
//   forwarded with the wait mask cleared. Done feedback from the core
//   decrements the counters.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for an instruction (s_axis_inst_tready = 1)
//   WAIT  | instruction held; checking wait mask and overflow guard
//   ISSUE | command presented on pccmd stream, waiting for tready
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_axis_inst_*         instruction stream in ([2:0] type, [31:29] wait mask)
//   m_axis_pccmd_*        command stream out (instruction with [31:29] = 0)
//   s_axis_pcfbk_*        done feedback in (bit0 store, bit1 exec, bit2/3 load)
//   outst_load/exec/store outstanding-operation counters
//   sched_idle            IDLE with all counters at zero
//   err_underflow         sticky: feedback arrived for an empty class
// -----------------------------------------------------------------------------
module pccmd_sched #(
  parameter int AXIS_PCCMD_DATA_WIDTH = 32,
  parameter int AXIS_PCFBK_DATA_WIDTH = 8,
  parameter int OUTST_WIDTH           = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic                             s_axis_inst_tvalid,
  output logic                             s_axis_inst_tready,
  input  logic [AXIS_PCCMD_DATA_WIDTH-1:0] s_axis_inst_tdata,

  output logic                             m_axis_pccmd_tvalid,
  input  logic                             m_axis_pccmd_tready,
  output logic [AXIS_PCCMD_DATA_WIDTH-1:0] m_axis_pccmd_tdata,

  input  logic                             s_axis_pcfbk_tvalid,
  output logic                             s_axis_pcfbk_tready,
  input  logic [AXIS_PCFBK_DATA_WIDTH-1:0] s_axis_pcfbk_tdata,

  output logic [OUTST_WIDTH-1:0]           outst_load,
  output logic [OUTST_WIDTH-1:0]           outst_exec,
  output logic [OUTST_WIDTH-1:0]           outst_store,
  output logic                             sched_idle,
  output logic                             err_underflow
);

  // Counter arithmetic runs two bits wider so +2 and the net of
  // increment/decrement can be compared without wrap.
  localparam int CW = OUTST_WIDTH + 2;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << OUTST_WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                           state_q;
  logic [AXIS_PCCMD_DATA_WIDTH-1:0] held_q;
  logic                             inst_tready_q;
  logic                             cmd_tvalid_q;
  logic [AXIS_PCCMD_DATA_WIDTH-1:0] cmd_tdata_q;
  logic [OUTST_WIDTH-1:0]           load_q,  exec_q,  store_q;
  logic [OUTST_WIDTH-1:0]           load_d,  exec_d,  store_d;
  logic                             err_q,   err_d;

  logic [CW-1:0] inc_load, inc_exec, inc_store;
  logic [CW-1:0] dec_load, dec_exec, dec_store;
  logic [CW-1:0] sum_load, sum_exec, sum_store;
  logic          uf_load,  uf_exec,  uf_store;
  logic          dep_ok, room_ok, cmd_fire;
  logic [AXIS_PCCMD_DATA_WIDTH-1:0] cmd_word;

  // Returns {underflow, saturated count} for sum - dec.
  function automatic logic [OUTST_WIDTH:0] apply_net(input logic [CW-1:0] sum,
                                                     input logic [CW-1:0] dec);
    if (dec > sum) apply_net = {1'b1, {OUTST_WIDTH{1'b0}}};
    else           apply_net = {1'b0, OUTST_WIDTH'(sum - dec)};
  endfunction

  // Class increment of the held instruction.
  always_comb begin
    inc_load  = '0;
    inc_exec  = '0;
    inc_store = '0;
    case (held_q[2:0])
      3'b001:  inc_load  = CW'(2);
      3'b010:  inc_load  = CW'(1);
      3'b011:  inc_store = CW'(1);
      default: ;
    endcase
    if (held_q[2]) inc_exec = CW'(1);
  end

  always_comb begin
    dep_ok  = (!held_q[29] || (store_q == '0)) &&
              (!held_q[30] || (exec_q  == '0)) &&
              (!held_q[31] || (load_q  == '0));
    room_ok = (({2'b00, load_q}  + inc_load)  <= CNT_MAX) &&
              (({2'b00, exec_q}  + inc_exec)  <= CNT_MAX) &&
              (({2'b00, store_q} + inc_store) <= CNT_MAX);
  end

  always_comb begin
    cmd_word          = held_q;
    cmd_word[31:29]   = 3'b000;
  end

  // Net counter update: issue increment and feedback decrement in one cycle.
  always_comb begin
    cmd_fire  = cmd_tvalid_q && m_axis_pccmd_tready;
    dec_store = CW'(s_axis_pcfbk_tvalid & s_axis_pcfbk_tdata[0]);
    dec_exec  = CW'(s_axis_pcfbk_tvalid & s_axis_pcfbk_tdata[1]);
    dec_load  = CW'(s_axis_pcfbk_tvalid & s_axis_pcfbk_tdata[2]) +
                CW'(s_axis_pcfbk_tvalid & s_axis_pcfbk_tdata[3]);
    sum_load  = {2'b00, load_q}  + (cmd_fire ? inc_load  : '0);
    sum_exec  = {2'b00, exec_q}  + (cmd_fire ? inc_exec  : '0);
    sum_store = {2'b00, store_q} + (cmd_fire ? inc_store : '0);
    {uf_load,  load_d}  = apply_net(sum_load,  dec_load);
    {uf_exec,  exec_d}  = apply_net(sum_exec,  dec_exec);
    {uf_store, store_d} = apply_net(sum_store, dec_store);
    err_d = err_q | uf_load | uf_exec | uf_store;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      held_q        <= '0;
      inst_tready_q <= 1'b1;
      cmd_tvalid_q  <= 1'b0;
      cmd_tdata_q   <= '0;
      load_q        <= '0;
      exec_q        <= '0;
      store_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      load_q  <= load_d;
      exec_q  <= exec_d;
      store_q <= store_d;
      err_q   <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (s_axis_inst_tvalid && inst_tready_q) begin
            held_q        <= s_axis_inst_tdata;
            inst_tready_q <= 1'b0;
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dep_ok && room_ok) begin
            cmd_tvalid_q <= 1'b1;
            cmd_tdata_q  <= cmd_word;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_axis_pccmd_tready) begin
            cmd_tvalid_q  <= 1'b0;
            inst_tready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          cmd_tvalid_q  <= 1'b0;
          inst_tready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  // Feedback bits above [3] carry no meaning here.
  generate
    if (AXIS_PCFBK_DATA_WIDTH > 4) begin : g_fbk_spare
      logic unused_fbk;
      assign unused_fbk = ^s_axis_pcfbk_tdata[AXIS_PCFBK_DATA_WIDTH-1:4];
    end
  endgenerate

  assign s_axis_inst_tready  = inst_tready_q;
  assign m_axis_pccmd_tvalid = cmd_tvalid_q;
  assign m_axis_pccmd_tdata  = cmd_tdata_q;
  assign s_axis_pcfbk_tready = 1'b1;
  assign outst_load          = load_q;
  assign outst_exec          = exec_q;
  assign outst_store         = store_q;
  assign err_underflow       = err_q;
  assign sched_idle          = (state_q == ST_IDLE) && (load_q == '0) &&
                               (exec_q == '0) && (store_q == '0);

endmodule

// File: tb/tb_pccmd_sched.sv
// -----------------------------------------------------------------------------
// tb_pccmd_sched
//   Directed scenarios followed by a randomized run checked against a
//   transaction-level model (integer counters, pending-instruction tracking).
// -----------------------------------------------------------------------------
module tb_pccmd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready;
  logic [31:0] m_tdata;
  logic        f_tvalid, f_tready;
  logic [7:0]  f_tdata;
  logic [3:0]  outst_load, outst_exec, outst_store;
  logic        sched_idle, err_underflow;

  always #5 clk = ~clk;

  pccmd_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_inst_tvalid  (s_tvalid),
    .s_axis_inst_tready  (s_tready),
    .s_axis_inst_tdata   (s_tdata),
    .m_axis_pccmd_tvalid (m_tvalid),
    .m_axis_pccmd_tready (m_tready),
    .m_axis_pccmd_tdata  (m_tdata),
    .s_axis_pcfbk_tvalid (f_tvalid),
    .s_axis_pcfbk_tready (f_tready),
    .s_axis_pcfbk_tdata  (f_tdata),
    .outst_load          (outst_load),
    .outst_exec          (outst_exec),
    .outst_store         (outst_store),
    .sched_idle          (sched_idle),
    .err_underflow       (err_underflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    f_tvalid = 1'b0;
    f_tdata  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] w);
    int b = 0;
    while (!s_tready && b < 60) begin tick(); b++; end
    check("send_ready", 32'(s_tready), 32'd1);
    s_tdata  = w;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  // Caller keeps m_tready high; consumes one command.
  task automatic wait_issue(input string tag, input logic [31:0] exp);
    int b = 0;
    while (!m_tvalid && b < 60) begin tick(); b++; end
    check({tag, "_vld"}, 32'(m_tvalid), 32'd1);
    check({tag, "_data"}, m_tdata, exp);
    tick();
  endtask

  task automatic feedback(input logic [7:0] f);
    f_tvalid = 1'b1;
    f_tdata  = f;
    tick();
    f_tvalid = 1'b0;
    f_tdata  = '0;
  endtask

  // Reference rules for the randomized run.
  function automatic int cls_load(input logic [2:0] t);
    if (t == 3'b001) return 2;
    if (t == 3'b010) return 1;
    return 0;
  endfunction
  function automatic int cls_store(input logic [2:0] t);
    return (t == 3'b011) ? 1 : 0;
  endfunction
  function automatic int cls_exec(input logic [2:0] t);
    return t[2] ? 1 : 0;
  endfunction
  function automatic bit may_issue(input logic [31:0] w, input int l, input int e, input int s);
    bit ok;
    ok = 1'b1;
    if (w[29] && s != 0) ok = 1'b0;
    if (w[30] && e != 0) ok = 1'b0;
    if (w[31] && l != 0) ok = 1'b0;
    if (l + cls_load(w[2:0])  > 15) ok = 1'b0;
    if (e + cls_exec(w[2:0])  > 15) ok = 1'b0;
    if (s + cls_store(w[2:0]) > 15) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    int          ml, me, ms;
    bit          merr, pend, in_wait, was_wait, acc, fire, c_ok;
    logic [31:0] pword;
    logic [7:0]  fb;
    int          seen;

    m_tready = 1'b1;
    do_reset();

    // Reset values
    check("rst_sready", 32'(s_tready), 32'd1);
    check("rst_mvalid", 32'(m_tvalid), 32'd0);
    check("rst_mdata",  m_tdata, 32'd0);
    check("rst_cnt",    {20'd0, outst_load, outst_exec, outst_store}, 32'd0);
    check("rst_err",    32'(err_underflow), 32'd0);
    check("rst_idle",   32'(sched_idle), 32'd1);
    check("rst_fready", 32'(f_tready), 32'd1);

    // No-wait passthrough, exact latency
    send(32'h0000_0100);
    check("pt_t1_sready", 32'(s_tready), 32'd0);
    check("pt_t1_mvalid", 32'(m_tvalid), 32'd0);
    tick();
    check("pt_t2_mvalid", 32'(m_tvalid), 32'd1);
    check("pt_t2_mdata",  m_tdata, 32'h0000_0100);
    tick();
    check("pt_t3_sready", 32'(s_tready), 32'd1);
    check("pt_t3_mvalid", 32'(m_tvalid), 32'd0);
    check("pt_t3_cnt",    {20'd0, outst_load, outst_exec, outst_store}, 32'd0);

    // Load int8 then exec waiting on load
    send(32'h0000_0041);
    wait_issue("le_load", 32'h0000_0041);
    check("le_load2", 32'(outst_load), 32'd2);
    send(32'h8000_0044);
    repeat (4) tick();
    check("le_hold1", 32'(m_tvalid), 32'd0);
    feedback(8'h04);
    check("le_load1", 32'(outst_load), 32'd1);
    repeat (3) tick();
    check("le_hold2", 32'(m_tvalid), 32'd0);
    feedback(8'h08);
    check("le_load0", 32'(outst_load), 32'd0);
    check("le_f1_mvalid", 32'(m_tvalid), 32'd0);
    tick();
    check("le_f2_mvalid", 32'(m_tvalid), 32'd1);
    check("le_f2_mdata",  m_tdata, 32'h0000_0044);
    tick();
    check("le_exec1", 32'(outst_exec), 32'd1);

    // Simultaneous loadx/loady
    do_reset();
    send(32'h0000_0001);
    wait_issue("sim_load", 32'h0000_0001);
    check("sim_load2", 32'(outst_load), 32'd2);
    feedback(8'h0C);
    check("sim_load0", 32'(outst_load), 32'd0);
    check("sim_err",   32'(err_underflow), 32'd0);

    // Overflow guard on store
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(32'h0000_0003);
      wait_issue("ov_st", 32'h0000_0003);
    end
    check("ov_store15", 32'(outst_store), 32'd15);
    send(32'h0000_0003);
    repeat (5) tick();
    check("ov_hold",    32'(m_tvalid), 32'd0);
    check("ov_still15", 32'(outst_store), 32'd15);
    feedback(8'h01);
    check("ov_store14", 32'(outst_store), 32'd14);
    wait_issue("ov_16th", 32'h0000_0003);
    check("ov_back15", 32'(outst_store), 32'd15);

    // Backpressure with underflow feedback
    do_reset();
    m_tready = 1'b0;
    send(32'hE000_0108);
    tick();
    check("bp_mvalid0", 32'(m_tvalid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      f_tvalid = (i == 3);
      f_tdata  = (i == 3) ? 8'h02 : 8'h00;
      tick();
      check("bp_mvalid", 32'(m_tvalid), 32'd1);
      check("bp_mdata",  m_tdata, 32'h0000_0108);
    end
    f_tvalid = 1'b0;
    check("bp_err", 32'(err_underflow), 32'd1);
    m_tready = 1'b1;
    tick();
    check("bp_done", 32'(m_tvalid), 32'd0);
    repeat (5) tick();
    check("bp_err_sticky", 32'(err_underflow), 32'd1);
    do_reset();
    check("bp_err_clr", 32'(err_underflow), 32'd0);

    // Reset while an instruction is held in WAIT
    send(32'h0000_0001);
    wait_issue("rw_load", 32'h0000_0001);
    send(32'h8000_0044);
    tick();
    tick();
    check("rw_held", 32'(m_tvalid), 32'd0);
    rst_n    = 1'b0;
    f_tvalid = 1'b1;
    f_tdata  = 8'h02;
    tick();
    rst_n    = 1'b1;
    f_tvalid = 1'b0;
    f_tdata  = '0;
    check("rw_sready", 32'(s_tready), 32'd1);
    check("rw_mvalid", 32'(m_tvalid), 32'd0);
    check("rw_cnt",    {20'd0, outst_load, outst_exec, outst_store}, 32'd0);
    check("rw_idle",   32'(sched_idle), 32'd1);
    check("rw_err",    32'(err_underflow), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_tvalid) seen++;
    end
    check("rw_noissue", 32'(seen), 32'd0);

    // Randomized run against the transaction-level model
    do_reset();
    ml = 0; me = 0; ms = 0; merr = 1'b0;
    pend = 1'b0; in_wait = 1'b0; pword = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!s_tvalid && $urandom_range(0, 2) == 0) begin
        s_tdata[2:0]   = 3'($urandom_range(0, 7));
        s_tdata[28:3]  = 26'($urandom);
        s_tdata[31:29] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
        s_tvalid       = 1'b1;
      end
      m_tready = ($urandom_range(0, 3) != 0);
      fb = 8'($urandom) & 8'hF0;
      if (ms > 0 && $urandom_range(0, 2) == 0) fb[0] = 1'b1;
      if (me > 0 && $urandom_range(0, 2) == 0) fb[1] = 1'b1;
      if (ml > 0 && $urandom_range(0, 2) == 0) fb[2] = 1'b1;
      if (ml > 1 && $urandom_range(0, 2) == 0) fb[3] = 1'b1;
      if ($urandom_range(0, 199) == 0) fb[3:0] = 4'($urandom);
      f_tdata  = fb;
      f_tvalid = ($urandom_range(0, 1) == 1);

      acc  = s_tvalid && s_tready;
      fire = m_tvalid && m_tready;
      c_ok = may_issue(pword, ml, me, ms);

      if (fire) begin
        check("rnd_data", m_tdata, pword & 32'h1FFF_FFFF);
        ml += cls_load(pword[2:0]);
        me += cls_exec(pword[2:0]);
        ms += cls_store(pword[2:0]);
        pend = 1'b0;
      end
      if (f_tvalid) begin
        ml -= int'(fb[2]) + int'(fb[3]);
        me -= int'(fb[1]);
        ms -= int'(fb[0]);
      end
      if (ml < 0) begin ml = 0; merr = 1'b1; end
      if (me < 0) begin me = 0; merr = 1'b1; end
      if (ms < 0) begin ms = 0; merr = 1'b1; end

      was_wait = in_wait;
      if (acc) begin
        pword = s_tdata;
        pend  = 1'b1;
      end
      tick();
      if (acc) begin
        s_tvalid = 1'b0;
        in_wait  = 1'b1;
      end else if (was_wait && c_ok) begin
        in_wait = 1'b0;
      end
      check("rnd_mvalid", 32'(m_tvalid), 32'(pend && !in_wait));
      check("rnd_sready", 32'(s_tready), 32'(!pend));
      check("rnd_load",   32'(outst_load),  32'(ml));
      check("rnd_exec",   32'(outst_exec),  32'(me));
      check("rnd_store",  32'(outst_store), 32'(ms));
      check("rnd_err",    32'(err_underflow), 32'(merr));
      check("rnd_idle",   32'(sched_idle), 32'(!pend && ml == 0 && me == 0 && ms == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
